acq_sequencer: RTL and testbench

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

---
 rtl/acq_sequencer.sv | 166 ++++++++++++++++
 tb/tb_acq_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : acq_sequencer
//  Description : Sampling acquisition sequencer. Ticks a programmable divider
//                while running, masks the channel inputs on each tick, packs
//                byte pairs in narrow mode and issues registered FIFO writes.
//                A refused word halts acquisition and sets a sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module acq_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        acq_enable,
  input  logic [7:0]  clock_divisor,
  input  logic [15:0] channel_select,
  input  logic [15:0] sample_in,
  input  logic        fifo_full,
  output logic        fifo_wr,
  output logic [15:0] fifo_data,
  output logic        running,
  output logic        overflow,
  output logic [15:0] word_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] mask_q, mask_d;
  logic [7:0]  divcnt_q, divcnt_d;
  logic        have_q, have_d;
  logic [7:0]  byte_q, byte_d;
  logic        wr_q, wr_d;
  logic [15:0] data_q, data_d;
  logic        ovf_q, ovf_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        running_w;

  // A tick is only honoured while enabled; a disable wins over a coincident tick.
  logic        tick_w;
  logic [15:0] masked_w;
  logic        wide_w;
  logic        produce_w;
  logic        store_w;
  logic        drop_w;
  logic [15:0] word_w;

  assign tick_w    = (state_q == ST_RUN) && acq_enable && (divcnt_q == 8'd0);
  assign masked_w  = sample_in & mask_q;
  assign wide_w    = |mask_q[15:8];
  assign produce_w = tick_w && (wide_w || have_q);
  assign store_w   = tick_w && !wide_w && !have_q;
  assign drop_w    = produce_w && fifo_full;
  assign word_w    = wide_w ? masked_w : {masked_w[7:0], byte_q};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acq_enable) state_d = ST_ARM;
      ST_ARM:  state_d = ST_RUN;
      ST_RUN: begin
        if (!acq_enable)  state_d = ST_IDLE;
        else if (drop_w)  state_d = ST_HALT;
      end
      ST_HALT: if (!acq_enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    running_w = (state_q == ST_ARM) || (state_q == ST_RUN);
  end

  // Datapath next values: config latch, divider, byte packing, write staging.
  always_comb begin
    div_d    = div_q;
    mask_d   = mask_q;
    divcnt_d = divcnt_q;
    have_d   = have_q;
    byte_d   = byte_q;
    wr_d     = 1'b0;
    data_d   = data_q;
    ovf_d    = ovf_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      ST_ARM: begin
        div_d    = clock_divisor;
        mask_d   = channel_select;
        divcnt_d = 8'd0;
        have_d   = 1'b0;
        byte_d   = 8'd0;
        ovf_d    = 1'b0;
        wcnt_d   = 16'd0;
      end
      ST_RUN: begin
        if (!acq_enable) begin
          // Leaving RUN: a half-packed byte must not leak into the next run.
          have_d = 1'b0;
          byte_d = 8'd0;
        end else begin
          divcnt_d = (divcnt_q == div_q) ? 8'd0 : divcnt_q + 8'd1;
          if (store_w) begin
            byte_d = masked_w[7:0];
            have_d = 1'b1;
          end
          if (produce_w) begin
            have_d = 1'b0;
            byte_d = 8'd0;
            if (fifo_full) begin
              ovf_d = 1'b1;
            end else begin
              wr_d   = 1'b1;
              data_d = word_w;
              wcnt_d = wcnt_q + 16'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= 8'd0;
      mask_q   <= 16'd0;
      divcnt_q <= 8'd0;
      have_q   <= 1'b0;
      byte_q   <= 8'd0;
      wr_q     <= 1'b0;
      data_q   <= 16'd0;
      ovf_q    <= 1'b0;
      wcnt_q   <= 16'd0;
    end else begin
      div_q    <= div_d;
      mask_q   <= mask_d;
      divcnt_q <= divcnt_d;
      have_q   <= have_d;
      byte_q   <= byte_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign fifo_wr    = wr_q;
  assign fifo_data  = data_q;
  assign running    = running_w;
  assign overflow   = ovf_q;
  assign word_count = wcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acq_sequencer
//  Description : Self-checking bench for acq_sequencer: vector table, directed
//                multi-cycle sequences and randomized traffic against a
//                behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acq_enable = 1'b0;
  logic [7:0]  clock_divisor = 8'd0;
  logic [15:0] channel_select = 16'd0;
  logic [15:0] sample_in = 16'd0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr;
  logic [15:0] fifo_data;
  logic        running;
  logic        overflow;
  logic [15:0] word_count;

  acq_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .acq_enable     (acq_enable),
    .clock_divisor  (clock_divisor),
    .channel_select (channel_select),
    .sample_in      (sample_in),
    .fifo_full      (fifo_full),
    .fifo_wr        (fifo_wr),
    .fifo_data      (fifo_data),
    .running        (running),
    .overflow       (overflow),
    .word_count     (word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_cycles[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (phase, run-cycle index, tick number) ----
  int          m_phase = 0;   // 0 idle, 1 arm, 2 run, 3 halt
  int          m_div = 0;
  logic [15:0] m_mask = 0;
  int          m_runidx = 0;
  int          m_ticks = 0;
  logic [7:0]  m_byte = 0;
  logic        m_wr = 0;
  logic [15:0] m_data = 0;
  logic        m_ovf = 0;
  logic [15:0] m_cnt = 0;

  task automatic model_step();
    logic [15:0] masked;
    logic [15:0] word;
    logic        wide;
    m_wr = 1'b0;
    if (rst) begin
      m_phase = 0; m_div = 0; m_mask = 0; m_runidx = 0; m_ticks = 0;
      m_byte = 0; m_data = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      case (m_phase)
        0: if (acq_enable) m_phase = 1;
        1: begin
          m_div = int'(clock_divisor); m_mask = channel_select;
          m_runidx = 0; m_ticks = 0; m_ovf = 0; m_cnt = 0;
          m_phase = 2;
        end
        2: begin
          if (!acq_enable) m_phase = 0;
          else begin
            if (m_runidx % (m_div + 1) == 0) begin
              m_ticks++;
              masked = sample_in & m_mask;
              wide   = (m_mask[15:8] != 8'h00);
              if (wide || (m_ticks % 2 == 0)) begin
                word = wide ? masked : {masked[7:0], m_byte};
                if (fifo_full) begin
                  m_ovf = 1'b1;
                  m_phase = 3;
                end else begin
                  m_wr = 1'b1; m_data = word; m_cnt = m_cnt + 16'd1;
                end
              end else begin
                m_byte = masked[7:0];
              end
            end
            m_runidx++;
          end
        end
        default: if (!acq_enable) m_phase = 0;
      endcase
    end
  endtask

  // One clock: model predicts, DUT steps, outputs compared one time unit later.
  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    cyc++;
    chk("fifo_wr",    fifo_wr,    m_wr);
    chk("fifo_data",  fifo_data,  m_data);
    chk("running",    running,    (m_phase == 1 || m_phase == 2));
    chk("overflow",   overflow,   m_ovf);
    chk("word_count", word_count, m_cnt);
    if (fifo_wr) wr_cycles.push_back(cyc);
  endtask

  task automatic setin(input logic r, input logic e, input logic [7:0] d,
                       input logic [15:0] m, input logic [15:0] s, input logic f);
    rst = r; acq_enable = e; clock_divisor = d; channel_select = m;
    sample_in = s; fifo_full = f;
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  div;
    logic [15:0] mask;
    logic [15:0] sample;
    logic        full;
    logic        wr;
    logic [15:0] data;
    logic        run;
    logic        ovf;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int e;
    //            rst en div    mask      sample    full wr data      run ovf cnt
    tbl[0]  = '{1'b1,1'b0,8'd0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,1'b0,1'b0,16'd0};
    tbl[1]  = '{1'b0,1'b1,8'd1,16'h0F0F,16'h0000,1'b0,1'b0,16'h0000,1'b1,1'b0,16'd0};
    tbl[2]  = '{1'b0,1'b1,8'd1,16'h0F0F,16'h0000,1'b0,1'b0,16'h0000,1'b1,1'b0,16'd0};
    tbl[3]  = '{1'b0,1'b1,8'd7,16'hFFFF,16'h1234,1'b0,1'b1,16'h0204,1'b1,1'b0,16'd1};
    tbl[4]  = '{1'b0,1'b1,8'd7,16'hFFFF,16'hFFFF,1'b0,1'b0,16'h0204,1'b1,1'b0,16'd1};
    tbl[5]  = '{1'b0,1'b1,8'd7,16'hFFFF,16'hABCD,1'b0,1'b1,16'h0B0D,1'b1,1'b0,16'd2};
    tbl[6]  = '{1'b0,1'b1,8'd7,16'hFFFF,16'h0000,1'b0,1'b0,16'h0B0D,1'b1,1'b0,16'd2};
    tbl[7]  = '{1'b0,1'b1,8'd7,16'hFFFF,16'hFFFF,1'b1,1'b0,16'h0B0D,1'b0,1'b1,16'd2};
    tbl[8]  = '{1'b0,1'b1,8'd7,16'hFFFF,16'hFFFF,1'b0,1'b0,16'h0B0D,1'b0,1'b1,16'd2};
    tbl[9]  = '{1'b0,1'b0,8'd7,16'hFFFF,16'hFFFF,1'b0,1'b0,16'h0B0D,1'b0,1'b1,16'd2};
    tbl[10] = '{1'b0,1'b1,8'd0,16'h00FF,16'h0000,1'b0,1'b0,16'h0B0D,1'b1,1'b1,16'd2};
    tbl[11] = '{1'b0,1'b1,8'd0,16'h00FF,16'h0000,1'b0,1'b0,16'h0B0D,1'b1,1'b0,16'd0};
    tbl[12] = '{1'b0,1'b1,8'd0,16'h00FF,16'hFF11,1'b0,1'b0,16'h0B0D,1'b1,1'b0,16'd0};
    tbl[13] = '{1'b0,1'b1,8'd0,16'h00FF,16'hEE22,1'b0,1'b1,16'h2211,1'b1,1'b0,16'd1};
    tbl[14] = '{1'b0,1'b1,8'd0,16'h00FF,16'h0033,1'b0,1'b0,16'h2211,1'b1,1'b0,16'd1};
    tbl[15] = '{1'b0,1'b0,8'd0,16'h00FF,16'h0044,1'b0,1'b0,16'h2211,1'b0,1'b0,16'd1};
    tbl[16] = '{1'b1,1'b0,8'd0,16'h00FF,16'h0055,1'b0,1'b0,16'h0000,1'b0,1'b0,16'd0};

    // ---- vector table ----
    for (int i = 0; i < 17; i++) begin
      setin(tbl[i].rst, tbl[i].en, tbl[i].div, tbl[i].mask, tbl[i].sample, tbl[i].full);
      cycle();
      chk($sformatf("v%0d_wr", i),   fifo_wr,    tbl[i].wr);
      chk($sformatf("v%0d_data", i), fifo_data,  tbl[i].data);
      chk($sformatf("v%0d_run", i),  running,    tbl[i].run);
      chk($sformatf("v%0d_ovf", i),  overflow,   tbl[i].ovf);
      chk($sformatf("v%0d_cnt", i),  word_count, tbl[i].cnt);
    end

    // ---- div=3 wide, constant sample, enable held 20 cycles ----
    setin(1'b1, 1'b0, 8'd3, 16'hFFFF, 16'hA5C3, 1'b0); cycle();
    wr_cycles.delete();
    e = cyc + 1;
    for (int i = 0; i < 20; i++) begin setin(1'b0, 1'b1, 8'd3, 16'hFFFF, 16'hA5C3, 1'b0); cycle(); end
    for (int i = 0; i < 3; i++)  begin setin(1'b0, 1'b0, 8'd3, 16'hFFFF, 16'hA5C3, 1'b0); cycle(); end
    chk("d3_nwrites", wr_cycles.size(), 5);
    chk("d3_count", word_count, 16'd5);
    if (wr_cycles.size() == 5) begin
      chk("d3_first", wr_cycles[0], e + 2);
      for (int i = 1; i < 5; i++) chk("d3_gap", wr_cycles[i] - wr_cycles[i-1], 4);
    end

    // ---- divisor change mid-run is ignored until next ARM ----
    setin(1'b1, 1'b0, 8'd1, 16'hFFFF, 16'h1111, 1'b0); cycle();
    wr_cycles.delete();
    for (int i = 0; i < 2; i++)  begin setin(1'b0, 1'b1, 8'd1, 16'hFFFF, 16'h1111, 1'b0); cycle(); end
    for (int i = 0; i < 12; i++) begin setin(1'b0, 1'b1, 8'd7, 16'hFFFF, 16'h1111, 1'b0); cycle(); end
    chk("dchg_n1", wr_cycles.size(), 6);
    for (int i = 1; i < wr_cycles.size(); i++) chk("dchg_gap1", wr_cycles[i] - wr_cycles[i-1], 2);
    setin(1'b0, 1'b0, 8'd7, 16'hFFFF, 16'h1111, 1'b0); cycle();
    wr_cycles.delete();
    for (int i = 0; i < 26; i++) begin setin(1'b0, 1'b1, 8'd7, 16'hFFFF, 16'h1111, 1'b0); cycle(); end
    chk("dchg_n2", wr_cycles.size(), 3);
    for (int i = 1; i < wr_cycles.size(); i++) chk("dchg_gap2", wr_cycles[i] - wr_cycles[i-1], 8);

    // ---- narrow: single odd tick then disable; next run uses only its own bytes ----
    setin(1'b0, 1'b0, 8'd0, 16'h00FF, 16'h0000, 1'b0); cycle();
    wr_cycles.delete();
    setin(1'b0, 1'b1, 8'd0, 16'h00FF, 16'h0000, 1'b0); cycle(); cycle();
    setin(1'b0, 1'b1, 8'd0, 16'h00FF, 16'h00AA, 1'b0); cycle();
    setin(1'b0, 1'b0, 8'd0, 16'h00FF, 16'h00BB, 1'b0); cycle();
    chk("nar_nowr", wr_cycles.size(), 0);
    chk("nar_idle", running, 1'b0);
    setin(1'b0, 1'b1, 8'd0, 16'h00FF, 16'h0000, 1'b0); cycle(); cycle();
    setin(1'b0, 1'b1, 8'd0, 16'h00FF, 16'h0011, 1'b0); cycle();
    setin(1'b0, 1'b1, 8'd0, 16'h00FF, 16'h0022, 1'b0); cycle();
    chk("nar_wr", fifo_wr, 1'b1);
    chk("nar_word", fifo_data, 16'h2211);

    // ---- reset asserted on a producing tick cancels the write ----
    setin(1'b0, 1'b1, 8'd0, 16'h00FF, 16'h0033, 1'b0); cycle();
    setin(1'b1, 1'b1, 8'd0, 16'h00FF, 16'h0044, 1'b0); cycle();
    chk("rst_wr", fifo_wr, 1'b0);
    chk("rst_data", fifo_data, 16'h0000);
    chk("rst_cnt", word_count, 16'h0000);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) acq_enable = ~acq_enable;
      rst = ($urandom_range(0, 299) == 0);
      clock_divisor  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 3));
      channel_select = ($urandom_range(0, 1) == 1) ? {8'h00, 8'($urandom)} : 16'($urandom);
      sample_in      = 16'($urandom);
      fifo_full      = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
